spimem_flash_rd: RTL and testbench

- Read-only single-bit SPI NOR flash controller. It services the spimem_* word-read port that the instruction cache drives on its flash side.
- Issues READ (0x03) with a 24-bit address and streams consecutive 32-bit words. Chip select stays asserted while requests remain sequential.
- Holds one prefetched word so the cache's next-line preread completes without a new command.
- Sits between the instruction cache and the flash pins.

---
 rtl/spimem_flash_rd.sv | 201 ++++++++++++++++++++
 tb/tb_spimem_flash_rd.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spimem_flash_rd.sv
// Read-only single-bit SPI NOR flash controller (READ 0x03) behind the cache's
// spimem word-read port, with a one-word prefetch buffer and sequential streaming.
module spimem_flash_rd #(
  parameter int unsigned LOG_SIZE_MEM   = 24,
  parameter int unsigned CLK_DIV        = 1,
  parameter int unsigned CS_HIGH_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    reset_l,
  input  logic [LOG_SIZE_MEM-1:0] spimem_addr,
  input  logic                    spimem_valid,
  output logic                    spimem_ready,
  output logic [31:0]             spimem_rdata,
  output logic                    spi_cs_l,
  output logic                    spi_sck,
  output logic                    spi_mosi,
  input  logic                    spi_miso
);

  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned DESEL_W = (CS_HIGH_CYCLES > 1) ? $clog2(CS_HIGH_CYCLES) : 1;
  localparam logic [7:0]  CMD_READ = 8'h03;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_DATA,
    S_HOLD,
    S_DESEL
  } state_t;

  state_t                  r_state;
  logic [LOG_SIZE_MEM-1:0] r_next_addr;
  logic [LOG_SIZE_MEM-1:0] r_buf_addr;
  logic [31:0]             r_buf_data;
  logic                    r_buf_valid;
  logic [30:0]             r_shift;
  logic [30:0]             r_rx;
  logic [4:0]              r_bit;
  logic [DIV_W-1:0]        r_div;
  logic [DESEL_W-1:0]      r_desel;
  logic                    r_ready;
  logic [31:0]             r_rdata;
  logic                    r_cs_l;
  logic                    r_sck;
  logic                    r_mosi;

  logic        w_tick;
  logic        w_last;
  logic [31:0] w_cmd;
  logic [31:0] w_rx_next;
  logic [31:0] w_word;
  logic        w_buf_hit;
  logic        w_seq_hit;

  // SCK toggles when the divider wraps; a bit spans one low and one high half.
  assign w_tick    = (r_div == DIV_W'(CLK_DIV - 1));
  assign w_last    = (r_bit == 5'd31);
  assign w_cmd     = {CMD_READ, 24'(spimem_addr)};
  assign w_rx_next = {r_rx, spi_miso};
  // First flash byte lands in the low byte of the word.
  assign w_word    = {w_rx_next[7:0], w_rx_next[15:8], w_rx_next[23:16], w_rx_next[31:24]};
  assign w_buf_hit = (spimem_addr == r_buf_addr);
  assign w_seq_hit = (spimem_addr == r_next_addr);

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      r_state     <= S_IDLE;
      r_next_addr <= '0;
      r_buf_addr  <= '0;
      r_buf_data  <= '0;
      r_buf_valid <= 1'b0;
      r_shift     <= '0;
      r_rx        <= '0;
      r_bit       <= '0;
      r_div       <= '0;
      r_desel     <= '0;
      r_ready     <= 1'b0;
      r_rdata     <= '0;
      r_cs_l      <= 1'b1;
      r_sck       <= 1'b0;
      r_mosi      <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cs_l <= 1'b1;
          r_sck  <= 1'b0;
          if (spimem_valid) begin
            r_next_addr <= spimem_addr;
            r_mosi      <= w_cmd[31];
            r_shift     <= w_cmd[30:0];
            r_cs_l      <= 1'b0;
            r_bit       <= '0;
            r_div       <= '0;
            r_state     <= S_CMD;
          end
        end

        // Command and address go out MSB first, changing on SCK falling edges.
        S_CMD: begin
          if (w_tick) begin
            r_div <= '0;
            r_sck <= ~r_sck;
            if (r_sck) begin
              if (w_last) begin
                r_bit   <= '0;
                r_mosi  <= 1'b0;
                r_state <= S_DATA;
              end else begin
                r_bit   <= r_bit + 5'd1;
                r_mosi  <= r_shift[30];
                r_shift <= {r_shift[29:0], 1'b0};
              end
            end
          end else begin
            r_div <= r_div + DIV_W'(1);
          end
        end

        // MISO is sampled on the edge that raises SCK; the word completes on bit 31.
        S_DATA: begin
          if (w_tick) begin
            r_div <= '0;
            r_sck <= ~r_sck;
            if (!r_sck) begin
              r_rx <= w_rx_next[30:0];
              if (w_last) begin
                r_buf_data  <= w_word;
                r_buf_addr  <= r_next_addr;
                r_buf_valid <= 1'b1;
                r_next_addr <= r_next_addr + LOG_SIZE_MEM'(4);
              end
            end else if (w_last) begin
              r_bit   <= '0;
              r_state <= S_HOLD;
            end else begin
              r_bit <= r_bit + 5'd1;
            end
          end else begin
            r_div <= r_div + DIV_W'(1);
          end
        end

        // Flash paused with SCK low; the cycle of a ready pulse is skipped so the
        // cache's updated address is the one evaluated next.
        S_HOLD: begin
          if (!r_ready) begin
            if (spimem_valid) begin
              if (r_buf_valid) begin
                r_buf_valid <= 1'b0;
                if (w_buf_hit) begin
                  r_rdata <= r_buf_data;
                  r_ready <= 1'b1;
                end else begin
                  r_cs_l  <= 1'b1;
                  r_desel <= '0;
                  r_state <= S_DESEL;
                end
              end else if (w_seq_hit) begin
                r_div   <= '0;
                r_state <= S_DATA;
              end else begin
                r_cs_l  <= 1'b1;
                r_desel <= '0;
                r_state <= S_DESEL;
              end
            end else if (!r_buf_valid) begin
              r_div   <= '0;
              r_state <= S_DATA;
            end
          end
        end

        S_DESEL: begin
          r_cs_l <= 1'b1;
          r_sck  <= 1'b0;
          r_mosi <= 1'b0;
          if (r_desel == DESEL_W'(CS_HIGH_CYCLES - 1)) begin
            r_state <= S_IDLE;
          end else begin
            r_desel <= r_desel + DESEL_W'(1);
          end
        end

        default: begin
          r_cs_l  <= 1'b1;
          r_sck   <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign spimem_ready = r_ready;
  assign spimem_rdata = r_rdata;
  assign spi_cs_l     = r_cs_l;
  assign spi_sck      = r_sck;
  assign spi_mosi     = r_mosi;

endmodule

// File: tb/tb_spimem_flash_rd.sv
// Directed bench for spimem_flash_rd: behavioural SPI flash plus a cache-like
// requester stepping addresses one edge after each ready pulse.
module tb_spimem_flash_rd;

  logic        clk;
  logic        reset_l;
  logic [23:0] spimem_addr;
  logic        spimem_valid;
  logic        spimem_ready;
  logic [31:0] spimem_rdata;
  logic        spi_cs_l;
  logic        spi_sck;
  logic        spi_mosi;
  logic        spi_miso = 1'b0;

  int checks = 0;
  int errors = 0;

  spimem_flash_rd #(
    .LOG_SIZE_MEM  (24),
    .CLK_DIV       (1),
    .CS_HIGH_CYCLES(4)
  ) dut (
    .clk         (clk),
    .reset_l     (reset_l),
    .spimem_addr (spimem_addr),
    .spimem_valid(spimem_valid),
    .spimem_ready(spimem_ready),
    .spimem_rdata(spimem_rdata),
    .spi_cs_l    (spi_cs_l),
    .spi_sck     (spi_sck),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Flash contents: fixed bytes at 0x100..0x103, a simple pattern elsewhere.
  function automatic logic [7:0] fbyte(input logic [23:0] a);
    case (a)
      24'h000100: return 8'h11;
      24'h000101: return 8'h22;
      24'h000102: return 8'h33;
      24'h000103: return 8'h44;
      default:    return 8'(a[7:0] * 8'd7 + a[15:8] + 8'h3C);
    endcase
  endfunction

  function automatic logic [31:0] exp_word(input logic [23:0] a);
    return {fbyte(a + 24'd3), fbyte(a + 24'd2), fbyte(a + 24'd1), fbyte(a)};
  endfunction

  // Flash model: 32 command bits on SCK rise, data bits driven on SCK fall.
  int          f_cnt = 0;
  int          d_idx = 0;
  int          cmds  = 0;
  logic [31:0] f_in  = '0;
  logic [31:0] last_cmd = '0;
  logic [23:0] f_cmd_addr = '0;

  always @(posedge spi_cs_l or posedge spi_sck) begin
    if (spi_cs_l) begin
      f_cnt = 0;
    end else if (f_cnt < 32) begin
      f_in = {f_in[30:0], spi_mosi};
      f_cnt++;
      if (f_cnt == 32) begin
        cmds++;
        last_cmd   = f_in;
        f_cmd_addr = f_in[23:0];
      end
    end
  end

  always @(negedge spi_sck) begin
    logic [7:0] b;
    if (!spi_cs_l) begin
      if (f_cnt < 32) begin
        d_idx = 0;
      end else begin
        b        = fbyte(f_cmd_addr + 24'(d_idx / 8));
        spi_miso = b[3'(7 - (d_idx % 8))];
        d_idx++;
      end
    end
  end

  // Running counters sampled mid-cycle.
  int n_ready = 0;
  int n_cs_hi = 0;
  int n_viol  = 0;
  always @(negedge clk) begin
    if (spimem_ready) n_ready++;
    if (spi_cs_l) n_cs_hi++;
    if (spimem_ready && !spimem_valid) n_viol++;
  end

  task automatic wait_ready(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (spimem_ready) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  // Cache updates its request on the edge after it sees ready.
  task automatic cache_step(input logic v, input logic [23:0] a);
    @(posedge clk);
    #1;
    spimem_valid = v;
    spimem_addr  = a;
  endtask

  task automatic test_reset();
    reset_l      = 1'b0;
    spimem_valid = 1'b0;
    spimem_addr  = '0;
    repeat (4) @(negedge clk);
    checks++; if (spi_cs_l !== 1'b1) begin errors++; $display("FAIL reset_cs got %b want 1", spi_cs_l); end
    checks++; if (spi_sck !== 1'b0) begin errors++; $display("FAIL reset_sck got %b want 0", spi_sck); end
    checks++; if (spi_mosi !== 1'b0) begin errors++; $display("FAIL reset_mosi got %b want 0", spi_mosi); end
    checks++; if (spimem_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", spimem_ready); end
    checks++; if (spimem_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h want 0", spimem_rdata); end
    reset_l = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_cold_read();
    bit ok;
    spimem_addr  = 24'h000100;
    spimem_valid = 1'b1;
    wait_ready(132, ok);
    checks++; if (!ok) begin errors++; $display("FAIL cold_latency got no ready want ready within 132 clk"); end
    checks++; if (spimem_rdata !== 32'h44332211) begin errors++; $display("FAIL cold_rdata got %h want 44332211", spimem_rdata); end
    checks++; if (last_cmd !== 32'h03000100) begin errors++; $display("FAIL cold_mosi got %h want 03000100", last_cmd); end
    cache_step(1'b0, 24'h000104);
    @(negedge clk);
    checks++; if (spimem_ready !== 1'b0) begin errors++; $display("FAIL cold_pulse got %b want 0", spimem_ready); end
    checks++; if (spimem_rdata !== 32'h44332211) begin errors++; $display("FAIL cold_hold got %h want 44332211", spimem_rdata); end
  endtask

  task automatic test_line_fill();
    bit ok;
    int c0, cs0, r0;
    repeat (80) @(negedge clk);
    c0 = cmds; r0 = n_ready; cs0 = n_cs_hi;
    spimem_addr  = 24'h000200;
    spimem_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wait_ready((i == 0) ? 200 : 67, ok);
      checks++; if (!ok) begin errors++; $display("FAIL fill_ready word %0d got none want ready", i); end
      checks++; if (spimem_rdata !== exp_word(24'h000200 + 24'(4 * i)))
        begin errors++; $display("FAIL fill_rdata word %0d got %h want %h", i, spimem_rdata, exp_word(24'h000200 + 24'(4 * i))); end
      if (i == 0) cs0 = n_cs_hi;
      if (i < 7) cache_step(1'b1, 24'h000200 + 24'(4 * (i + 1)));
      else       cache_step(1'b0, 24'h000220);
    end
    checks++; if (cmds - c0 != 1) begin errors++; $display("FAIL fill_cmds got %0d want 1", cmds - c0); end
    checks++; if (n_cs_hi - cs0 != 0) begin errors++; $display("FAIL fill_cs_low got %0d high cycles want 0", n_cs_hi - cs0); end
    checks++; if (n_ready - r0 != 8) begin errors++; $display("FAIL fill_pulses got %0d want 8", n_ready - r0); end
  endtask

  task automatic test_prefetch();
    int c0, cs0;
    c0 = cmds; cs0 = n_cs_hi;
    repeat (200) @(negedge clk);
    spimem_valid = 1'b1;
    @(negedge clk);
    checks++; if (spimem_ready !== 1'b1) begin errors++; $display("FAIL pf_ready got %b want 1", spimem_ready); end
    checks++; if (spimem_rdata !== exp_word(24'h000220)) begin errors++; $display("FAIL pf_rdata got %h want %h", spimem_rdata, exp_word(24'h000220)); end
    checks++; if (cmds != c0) begin errors++; $display("FAIL pf_cmds got %0d new want 0", cmds - c0); end
    checks++; if (n_cs_hi != cs0) begin errors++; $display("FAIL pf_cs got %0d high cycles want 0", n_cs_hi - cs0); end
    cache_step(1'b0, 24'h000224);
  endtask

  task automatic test_wrapped_fill();
    bit ok;
    int c0, cs0;
    logic [23:0] a;
    repeat (80) @(negedge clk);
    c0 = cmds; cs0 = n_cs_hi;
    spimem_addr  = 24'h000310;
    spimem_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      a = 24'h000300 | ((24'h10 + 24'(4 * i)) & 24'h1F);
      wait_ready((i == 0 || i == 4) ? 200 : 67, ok);
      checks++; if (!ok) begin errors++; $display("FAIL wrap_ready word %0d got none want ready", i); end
      checks++; if (spimem_rdata !== exp_word(a)) begin errors++; $display("FAIL wrap_rdata word %0d got %h want %h", i, spimem_rdata, exp_word(a)); end
      if (i == 3) cs0 = n_cs_hi;
      if (i == 4) begin
        checks++; if (n_cs_hi - cs0 < 4) begin errors++; $display("FAIL wrap_cs_high got %0d want >=4", n_cs_hi - cs0); end
        checks++; if (last_cmd !== 32'h03000300) begin errors++; $display("FAIL wrap_cmd got %h want 03000300", last_cmd); end
      end
      if (i < 7) cache_step(1'b1, 24'h000300 | ((24'h10 + 24'(4 * (i + 1))) & 24'h1F));
      else       cache_step(1'b0, 24'h000310);
    end
    checks++; if (cmds - c0 != 2) begin errors++; $display("FAIL wrap_cmds got %0d want 2", cmds - c0); end
  endtask

  task automatic test_prefetch_miss();
    bit ok;
    int c0, cs0;
    repeat (80) @(negedge clk);
    spimem_addr  = 24'h000218;
    spimem_valid = 1'b1;
    wait_ready(200, ok);
    checks++; if (!ok || spimem_rdata !== exp_word(24'h000218)) begin errors++; $display("FAIL miss_setup0 got %h want %h", spimem_rdata, exp_word(24'h000218)); end
    cache_step(1'b1, 24'h00021C);
    wait_ready(67, ok);
    checks++; if (!ok || spimem_rdata !== exp_word(24'h00021C)) begin errors++; $display("FAIL miss_setup1 got %h want %h", spimem_rdata, exp_word(24'h00021C)); end
    cache_step(1'b0, 24'h000220);
    repeat (80) @(negedge clk);
    c0 = cmds; cs0 = n_cs_hi;
    spimem_addr  = 24'h004000;
    spimem_valid = 1'b1;
    wait_ready(200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL miss_ready got none want ready"); end
    checks++; if (spimem_rdata !== exp_word(24'h004000)) begin errors++; $display("FAIL miss_rdata got %h want %h", spimem_rdata, exp_word(24'h004000)); end
    checks++; if (last_cmd !== 32'h03004000) begin errors++; $display("FAIL miss_cmd got %h want 03004000", last_cmd); end
    checks++; if (cmds - c0 != 1) begin errors++; $display("FAIL miss_cmds got %0d want 1", cmds - c0); end
    checks++; if (n_cs_hi - cs0 < 4) begin errors++; $display("FAIL miss_cs_high got %0d want >=4", n_cs_hi - cs0); end
    cache_step(1'b0, 24'h004004);
  endtask

  task automatic test_reset_mid_data();
    bit ok;
    int c0, r0;
    repeat (80) @(negedge clk);
    c0 = cmds; r0 = n_ready;
    spimem_addr  = 24'h000500;
    spimem_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (cmds != c0) ok = 1'b1;
    end
    checks++; if (!ok) begin errors++; $display("FAIL rst_cmd_start got none want command"); end
    repeat (10) @(negedge clk);
    checks++; if (spi_cs_l !== 1'b0) begin errors++; $display("FAIL rst_in_data got cs %b want 0", spi_cs_l); end
    spimem_valid = 1'b0;
    reset_l      = 1'b0;
    #1;
    checks++; if (spi_cs_l !== 1'b1) begin errors++; $display("FAIL rst_cs_now got %b want 1", spi_cs_l); end
    checks++; if (spi_sck !== 1'b0) begin errors++; $display("FAIL rst_sck_now got %b want 0", spi_sck); end
    repeat (3) @(negedge clk);
    reset_l = 1'b1;
    @(negedge clk);
    checks++; if (n_ready != r0) begin errors++; $display("FAIL rst_no_ready got %0d pulses want 0", n_ready - r0); end
    spimem_addr  = 24'h000100;
    spimem_valid = 1'b1;
    wait_ready(132, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rst_after_ready got none want ready"); end
    checks++; if (spimem_rdata !== 32'h44332211) begin errors++; $display("FAIL rst_after_rdata got %h want 44332211", spimem_rdata); end
    checks++; if (last_cmd !== 32'h03000100) begin errors++; $display("FAIL rst_after_cmd got %h want 03000100", last_cmd); end
    cache_step(1'b0, 24'h000104);
  endtask

  initial begin
    test_reset();
    test_cold_read();
    test_line_fill();
    test_prefetch();
    test_wrapped_fill();
    test_prefetch_miss();
    test_reset_mid_data();
    repeat (4) @(negedge clk);
    checks++; if (n_viol != 0) begin errors++; $display("FAIL ready_without_valid got %0d want 0", n_viol); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
